// File: rtl/vga_timing_gen_pkg.sv
// Shared constants and types for the VGA timing path.
// Default raster is 640x480 @ 60 Hz: 800 pixels per line, 525 lines per frame.
package vga_pkg;

  localparam int COORD_W   = 10;
  localparam int COORD_LIM = 1 << COORD_W;

  typedef logic [COORD_W-1:0] coord_t;

  localparam int DEF_CLK_DIV   = 2;
  localparam int DEF_H_SYNC    = 96;
  localparam int DEF_H_BACK    = 48;
  localparam int DEF_H_VISIBLE = 640;
  localparam int DEF_H_FRONT   = 16;
  localparam int DEF_V_SYNC    = 2;
  localparam int DEF_V_BACK    = 33;
  localparam int DEF_V_VISIBLE = 480;
  localparam int DEF_V_FRONT   = 10;

  localparam int H_TOTAL = DEF_H_SYNC + DEF_H_BACK + DEF_H_VISIBLE + DEF_H_FRONT;
  localparam int V_TOTAL = DEF_V_SYNC + DEF_V_BACK + DEF_V_VISIBLE + DEF_V_FRONT;

  // Half-open window test: lo <= v < hi.
  function automatic logic in_window(input coord_t v, input coord_t lo, input coord_t hi);
    return (v >= lo) && (v < hi);
  endfunction

endpackage

// File: rtl/vga_timing_gen_pixel_tick_gen.sv
// Pixel-rate divider: produces a one-clock pixel strobe every CLK_DIV clocks
// and a registered pixel clock whose rising edge sits mid pixel period.
module pixel_tick_gen #(
  parameter int CLK_DIV = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic pixel_tick,
  output logic vga_clk
);

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [DIV_W-1:0] DIV_HALF = DIV_W'(CLK_DIV / 2);

  logic [DIV_W-1:0] div_cnt_reg;
  logic [DIV_W-1:0] div_cnt_next;
  logic             vga_clk_reg;

  // Divider advances only while scanning is enabled; wraps after the last phase.
  always_comb begin
    div_cnt_next = div_cnt_reg;
    if (en) begin
      div_cnt_next = (div_cnt_reg == DIV_LAST) ? '0 : div_cnt_reg + 1'b1;
    end
  end

  // vga_clk is decoded from the next divider phase so it stays aligned with div_cnt.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      div_cnt_reg <= '0;
      vga_clk_reg <= 1'b0;
    end else begin
      div_cnt_reg <= div_cnt_next;
      vga_clk_reg <= (div_cnt_next >= DIV_HALF);
    end
  end

  assign pixel_tick = en && (div_cnt_reg == DIV_LAST);
  assign vga_clk    = vga_clk_reg;

endmodule

// File: rtl/vga_timing_gen.sv
// VGA timing master: scans the raster one pixel per pixel_tick and decodes
// sync, visible-area and line/frame start pulses, all aligned to the coordinates.
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int CLK_DIV   = DEF_CLK_DIV,
  parameter int H_SYNC    = DEF_H_SYNC,
  parameter int H_BACK    = DEF_H_BACK,
  parameter int H_VISIBLE = DEF_H_VISIBLE,
  parameter int H_FRONT   = DEF_H_FRONT,
  parameter int V_SYNC    = DEF_V_SYNC,
  parameter int V_BACK    = DEF_V_BACK,
  parameter int V_VISIBLE = DEF_V_VISIBLE,
  parameter int V_FRONT   = DEF_V_FRONT
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  output logic       vga_clk,
  output logic       pixel_tick,
  output logic [9:0] pixelx,
  output logic [9:0] pixely,
  output logic       hsync,
  output logic       vsync,
  output logic       video_on,
  output logic       line_start,
  output logic       frame_start
);

  localparam int H_SUM = H_SYNC + H_BACK + H_VISIBLE + H_FRONT;
  localparam int V_SUM = V_SYNC + V_BACK + V_VISIBLE + V_FRONT;

  // Geometry that does not fit the 10-bit coordinates is rejected at elaboration.
  generate
    if ((H_SUM > COORD_LIM) || (V_SUM > COORD_LIM) || (CLK_DIV < 2)) begin : g_param_error
      $error("vga_timing_gen: raster exceeds coordinate range or CLK_DIV < 2");
    end
  endgenerate

  localparam coord_t H_LAST      = coord_t'(H_SUM - 1);
  localparam coord_t V_LAST      = coord_t'(V_SUM - 1);
  localparam coord_t H_SYNC_END  = coord_t'(H_SYNC);
  localparam coord_t V_SYNC_END  = coord_t'(V_SYNC);
  localparam coord_t H_VIS_START = coord_t'(H_SYNC + H_BACK);
  localparam coord_t H_VIS_END   = coord_t'(H_SYNC + H_BACK + H_VISIBLE);
  localparam coord_t V_VIS_START = coord_t'(V_SYNC + V_BACK);
  localparam coord_t V_VIS_END   = coord_t'(V_SYNC + V_BACK + V_VISIBLE);

  logic   tick;
  coord_t pixelx_reg, pixelx_next;
  coord_t pixely_reg, pixely_next;
  logic   line_wrap, frame_wrap;
  logic   hsync_reg, vsync_reg, video_on_reg;
  logic   line_start_reg, frame_start_reg;

  pixel_tick_gen #(
    .CLK_DIV (CLK_DIV)
  ) u_pixel_tick_gen (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .pixel_tick (tick),
    .vga_clk    (vga_clk)
  );

  // Next raster position: step x on each tick, carry into y at end of line.
  always_comb begin
    pixelx_next = pixelx_reg;
    pixely_next = pixely_reg;
    line_wrap   = tick && (pixelx_reg == H_LAST);
    frame_wrap  = line_wrap && (pixely_reg == V_LAST);
    if (tick) begin
      if (pixelx_reg == H_LAST) begin
        pixelx_next = '0;
        pixely_next = (pixely_reg == V_LAST) ? '0 : pixely_reg + 1'b1;
      end else begin
        pixelx_next = pixelx_reg + 1'b1;
      end
    end
  end

  // Counters plus decode from next values, so sync/video change with the coordinates.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pixelx_reg      <= '0;
      pixely_reg      <= '0;
      hsync_reg       <= 1'b0;
      vsync_reg       <= 1'b0;
      video_on_reg    <= 1'b0;
      line_start_reg  <= 1'b0;
      frame_start_reg <= 1'b0;
    end else begin
      pixelx_reg      <= pixelx_next;
      pixely_reg      <= pixely_next;
      hsync_reg       <= !(pixelx_next < H_SYNC_END);
      vsync_reg       <= !(pixely_next < V_SYNC_END);
      video_on_reg    <= in_window(pixelx_next, H_VIS_START, H_VIS_END) &&
                         in_window(pixely_next, V_VIS_START, V_VIS_END);
      line_start_reg  <= line_wrap;
      frame_start_reg <= frame_wrap;
    end
  end

  assign pixel_tick  = tick;
  assign pixelx      = pixelx_reg;
  assign pixely      = pixely_reg;
  assign hsync       = hsync_reg;
  assign vsync       = vsync_reg;
  assign video_on    = video_on_reg;
  assign line_start  = line_start_reg;
  assign frame_start = frame_start_reg;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench: default 800x525 raster for line/pause/reset behaviour and a
// small 17x12 raster (CLK_DIV=3) for whole-frame and wrap-boundary behaviour.
module tb_vga_timing_gen;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic       en_s;

  logic       vga_clk, pixel_tick, hsync, vsync, video_on, line_start, frame_start;
  logic [9:0] pixelx, pixely;

  logic       s_vga_clk, s_pixel_tick, s_hsync, s_vsync, s_video_on, s_line_start, s_frame_start;
  logic [9:0] s_pixelx, s_pixely;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  vga_timing_gen dut (
    .clk         (clk),
    .rst         (rst),
    .en          (en),
    .vga_clk     (vga_clk),
    .pixel_tick  (pixel_tick),
    .pixelx      (pixelx),
    .pixely      (pixely),
    .hsync       (hsync),
    .vsync       (vsync),
    .video_on    (video_on),
    .line_start  (line_start),
    .frame_start (frame_start)
  );

  vga_timing_gen #(
    .CLK_DIV (3),
    .H_SYNC (4), .H_BACK (3), .H_VISIBLE (8), .H_FRONT (2),
    .V_SYNC (2), .V_BACK (3), .V_VISIBLE (5), .V_FRONT (2)
  ) dut_s (
    .clk         (clk),
    .rst         (rst),
    .en          (en_s),
    .vga_clk     (s_vga_clk),
    .pixel_tick  (s_pixel_tick),
    .pixelx      (s_pixelx),
    .pixely      (s_pixely),
    .hsync       (s_hsync),
    .vsync       (s_vsync),
    .video_on    (s_video_on),
    .line_start  (s_line_start),
    .frame_start (s_frame_start)
  );

  task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end else begin
      $display("ok   %s = %0d", tag, obs);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  // default-instance line statistics
  int d_ticks, d_hs_low, d_vs_low, d_vid, d_vclk, d_ls, d_fs, d_hs_rise;
  // small-instance frame statistics
  int s_ticks, s_hs_low, s_vs_low, s_vid, s_vclk, s_ls, s_fs, s_fs_bad;
  int s_x_min, s_x_max, s_y_min, s_y_max;
  int frozen_bad;
  logic [23:0] snap;

  initial begin
    d_ticks = 0; d_hs_low = 0; d_vs_low = 0; d_vid = 0; d_vclk = 0; d_ls = 0; d_fs = 0;
    d_hs_rise = -1;
    s_ticks = 0; s_hs_low = 0; s_vs_low = 0; s_vid = 0; s_vclk = 0; s_ls = 0; s_fs = 0;
    s_fs_bad = 0;
    s_x_min = 1023; s_x_max = -1; s_y_min = 1023; s_y_max = -1;
    frozen_bad = 0;

    // Reset held with enable high: everything must sit at reset values.
    rst = 1'b0; en = 1'b1; en_s = 1'b1;
    repeat (4) @(negedge clk);
    check_value("rst_pixelx", 32'(pixelx), 0);
    check_value("rst_pixely", 32'(pixely), 0);
    check_value("rst_hsync", 32'(hsync), 0);
    check_value("rst_vsync", 32'(vsync), 0);
    check_value("rst_video_on", 32'(video_on), 0);
    check_value("rst_vga_clk", 32'(vga_clk), 0);
    check_value("rst_pixel_tick", 32'(pixel_tick), 0);
    check_value("rst_pulses", 32'({line_start, frame_start}), 0);
    check_value("rst_s_pixelx", 32'(s_pixelx), 0);

    // Release and scan: k counts clock edges since release.
    rst = 1'b1;
    for (int k = 1; k <= 1600; k++) begin
      step();
      if (pixel_tick) begin
        d_ticks++;
        if (!hsync) d_hs_low++;
        if (!vsync) d_vs_low++;
        if (video_on) d_vid++;
        if (hsync && d_hs_rise < 0) d_hs_rise = int'(pixelx);
      end
      if (vga_clk) d_vclk++;
      if (line_start) d_ls++;
      if (frame_start) d_fs++;

      if (k <= 1224) begin
        if (s_pixel_tick) begin
          s_ticks++;
          if (!s_hsync) s_hs_low++;
          if (!s_vsync) s_vs_low++;
          if (s_video_on) begin
            s_vid++;
            if (int'(s_pixelx) < s_x_min) s_x_min = int'(s_pixelx);
            if (int'(s_pixelx) > s_x_max) s_x_max = int'(s_pixelx);
            if (int'(s_pixely) < s_y_min) s_y_min = int'(s_pixely);
            if (int'(s_pixely) > s_y_max) s_y_max = int'(s_pixely);
          end
        end
        if (s_vga_clk) s_vclk++;
        if (s_line_start) s_ls++;
        if (s_frame_start) s_fs++;
        if (s_frame_start && !s_line_start) s_fs_bad++;
      end

      if (k == 1) begin
        check_value("first_tick", 32'(pixel_tick), 1);
        check_value("first_tick_x", 32'(pixelx), 0);
        check_value("first_vga_clk", 32'(vga_clk), 1);
      end
      if (k == 2) begin
        check_value("k2_pixelx", 32'(pixelx), 1);
        check_value("k2_vga_clk", 32'(vga_clk), 0);
      end
      if (k == 611) begin
        check_value("s_pre_wrap_xy", 32'({s_pixelx, s_pixely}), 32'({10'd16, 10'd11}));
        check_value("s_pre_wrap_tick", 32'(s_pixel_tick), 1);
        check_value("s_pre_wrap_fs", 32'(s_frame_start), 0);
      end
      if (k == 612) begin
        check_value("s_wrap_xy", 32'({s_pixelx, s_pixely}), 0);
        check_value("s_wrap_pulses", 32'({s_frame_start, s_line_start}), 3);
        check_value("s_wrap_syncs", 32'({s_hsync, s_vsync, s_video_on}), 0);
      end
      if (k == 613) begin
        check_value("s_post_wrap_pulses", 32'({s_frame_start, s_line_start}), 0);
      end
    end

    check_value("d_ticks_per_line", 32'(d_ticks), 800);
    check_value("d_hsync_low_ticks", 32'(d_hs_low), 96);
    check_value("d_hsync_rise_x", 32'(d_hs_rise), 96);
    check_value("d_vsync_low_line0", 32'(d_vs_low), 800);
    check_value("d_video_line0", 32'(d_vid), 0);
    check_value("d_vga_clk_high", 32'(d_vclk), 800);
    check_value("d_line_starts", 32'(d_ls), 1);
    check_value("d_frame_starts", 32'(d_fs), 0);
    check_value("d_line_end_xy", 32'({pixelx, pixely}), 32'({10'd0, 10'd1}));
    check_value("d_line_end_ls", 32'(line_start), 1);

    check_value("s_ticks", 32'(s_ticks), 408);
    check_value("s_hsync_low", 32'(s_hs_low), 96);
    check_value("s_vsync_low", 32'(s_vs_low), 68);
    check_value("s_video_ticks", 32'(s_vid), 80);
    check_value("s_video_x_min", 32'(s_x_min), 7);
    check_value("s_video_x_max", 32'(s_x_max), 14);
    check_value("s_video_y_min", 32'(s_y_min), 5);
    check_value("s_video_y_max", 32'(s_y_max), 9);
    check_value("s_vga_clk_high", 32'(s_vclk), 816);
    check_value("s_line_starts", 32'(s_ls), 24);
    check_value("s_frame_starts", 32'(s_fs), 2);
    check_value("s_fs_without_ls", 32'(s_fs_bad), 0);

    // Advance to pixelx=300 mid-tick on line 1, then pause for 37 clocks.
    repeat (601) step();
    check_value("pause_at_x", 32'(pixelx), 300);
    check_value("pause_at_tick", 32'(pixel_tick), 1);
    en = 1'b0;
    #1;
    check_value("pause_tick_low", 32'(pixel_tick), 0);
    snap = {pixelx, pixely, hsync, vsync, video_on, vga_clk};
    for (int p = 0; p < 37; p++) begin
      step();
      if ({pixelx, pixely, hsync, vsync, video_on, vga_clk} !== snap) frozen_bad++;
      if (pixel_tick || line_start || frame_start) frozen_bad++;
    end
    check_value("pause_frozen", 32'(frozen_bad), 0);
    check_value("pause_vsync", 32'(vsync), 0);
    check_value("pause_hsync", 32'(hsync), 1);

    // Resume: the held phase was the tick phase, so the tick is immediate.
    en = 1'b1;
    #1;
    check_value("resume_tick", 32'(pixel_tick), 1);
    step();
    check_value("resume_x", 32'(pixelx), 301);
    repeat (399) step();
    check_value("pre_reset_xy", 32'({pixelx, pixely}), 32'({10'd500, 10'd1}));

    // Asynchronous reset in the middle of a clock low phase.
    #2 rst = 1'b0;
    #1;
    check_value("async_rst_xy", 32'({pixelx, pixely}), 0);
    check_value("async_rst_tick_vclk", 32'({pixel_tick, vga_clk}), 0);
    check_value("async_rst_syncs", 32'({hsync, vsync, video_on}), 0);
    @(negedge clk);
    rst = 1'b1;
    step();
    check_value("post_rst_tick", 32'(pixel_tick), 1);
    check_value("post_rst_x_k1", 32'(pixelx), 0);
    step();
    check_value("post_rst_xy_k2", 32'({pixelx, pixely}), 32'({10'd1, 10'd0}));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
